// File: rtl/rr_hold_arbiter.sv
// Round-robin arbiter with grant hold; RR_ARB_STATS_EN adds grant/preempt counters.
// Latency: one edge from request to registered grant. Backpressure: none, the grant is the handshake.
module rr_hold_arbiter #(
    parameter int N        = 4,
    parameter int ID_W     = 2,
    parameter int MAX_HOLD = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] grant_id,
    output logic            busy
`ifdef RR_ARB_STATS_EN
    ,
    output logic [15:0]     grant_count,
    output logic [15:0]     preempt_count
`endif
);

    localparam int HC_W = $clog2(MAX_HOLD + 1);
    localparam logic [ID_W:0]   N_EXT   = N[ID_W:0];
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(N - 1);

    typedef enum logic {IDLE, OWN} state_t;

    state_t          state;
    logic [ID_W-1:0] ptr;
    logic [HC_W-1:0] hold_cnt;

    logic            own_req;
    logic            at_max;
    logic            release_own;
    logic            found;
    logic [N-1:0]    cand;
    logic [N-1:0]    rot;
    logic [ID_W-1:0] off;
    logic [ID_W:0]   sum;
    logic [ID_W-1:0] sel_id;

    function automatic logic [ID_W-1:0] inc_mod(input logic [ID_W-1:0] x);
        return (x == LAST_ID) ? '0 : x + ID_W'(1);
    endfunction

    function automatic logic [N-1:0] onehot(input logic [ID_W-1:0] i);
        return {{(N-1){1'b0}}, 1'b1} << i;
    endfunction

    // Grant is zero in IDLE, so masking off the owner also covers the idle pick.
    assign cand        = req & ~grant;
    assign found       = |cand;
    assign own_req     = |(req & grant);
    assign at_max      = (hold_cnt == HC_W'(MAX_HOLD));
    assign release_own = !own_req || at_max;

    // Rotate so bit j of rot is requester (ptr + j) mod N; lowest set bit wins.
    assign rot = N'({cand, cand} >> ptr);

    always_comb begin
        off = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (rot[j]) off = ID_W'(j);
        end
    end

    assign sum    = {1'b0, ptr} + {1'b0, off};
    assign sel_id = (sum >= N_EXT) ? ID_W'(sum - N_EXT) : sum[ID_W-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            ptr           <= '0;
            hold_cnt      <= '0;
            grant         <= '0;
            grant_id      <= '0;
            busy          <= 1'b0;
`ifdef RR_ARB_STATS_EN
            grant_count   <= '0;
            preempt_count <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        grant    <= onehot(sel_id);
                        grant_id <= sel_id;
                        busy     <= 1'b1;
                        hold_cnt <= HC_W'(1);
                        ptr      <= inc_mod(sel_id);
                        state    <= OWN;
`ifdef RR_ARB_STATS_EN
                        grant_count <= grant_count + 16'd1;
`endif
                    end
                end
                OWN: begin
`ifdef RR_ARB_STATS_EN
                    if (at_max && own_req) preempt_count <= preempt_count + 16'd1;
`endif
                    if (!release_own) begin
                        hold_cnt <= hold_cnt + HC_W'(1);
                    end else if (found) begin
                        grant    <= onehot(sel_id);
                        grant_id <= sel_id;
                        hold_cnt <= HC_W'(1);
                        ptr      <= inc_mod(sel_id);
`ifdef RR_ARB_STATS_EN
                        grant_count <= grant_count + 16'd1;
`endif
                    end else if (own_req) begin
                        // Sole requester hit the hold limit: re-grant without dropping.
                        hold_cnt <= HC_W'(1);
                        ptr      <= inc_mod(grant_id);
`ifdef RR_ARB_STATS_EN
                        grant_count <= grant_count + 16'd1;
`endif
                    end else begin
                        grant    <= '0;
                        grant_id <= '0;
                        busy     <= 1'b0;
                        hold_cnt <= '0;
                        state    <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// Directed bench for rr_hold_arbiter (N=4, MAX_HOLD=4); counters checked when RR_ARB_STATS_EN is defined.
module tb_rr_hold_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic       busy;
`ifdef RR_ARB_STATS_EN
    logic [15:0] grant_count;
    logic [15:0] preempt_count;
`endif

    int checks = 0;
    int errors = 0;

    rr_hold_arbiter #(.N(4), .ID_W(2), .MAX_HOLD(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .grant    (grant),
        .grant_id (grant_id),
        .busy     (busy)
`ifdef RR_ARB_STATS_EN
        ,
        .grant_count   (grant_count),
        .preempt_count (preempt_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic [3:0] g;
        logic [1:0] id;
    } vec_t;

    vec_t tbl[22];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input logic [3:0] eg, input logic [1:0] eid);
        chk($sformatf("%s grant", name), 32'(grant), 32'(eg));
        chk($sformatf("%s grant_id", name), 32'(grant_id), 32'(eid));
        chk($sformatf("%s busy", name), 32'(busy), 32'(|eg));
    endtask

    task automatic step(input logic [3:0] r);
        @(negedge clk);
        req = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        req = 4'b0000;
        rst = 1'b0;
        #1;
        chk_out("reset", 4'b0000, 2'd0);
`ifdef RR_ARB_STATS_EN
        chk("reset grant_count", 32'(grant_count), 32'd0);
        chk("reset preempt_count", 32'(preempt_count), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic [3:0] one;
        one = 4'b0001;

        // Vectors applied from a fresh reset (ptr=0), MAX_HOLD=4.
        tbl[0]  = '{4'b0100, 4'b0100, 2'd2};
        tbl[1]  = '{4'b0100, 4'b0100, 2'd2};
        tbl[2]  = '{4'b0100, 4'b0100, 2'd2};
        tbl[3]  = '{4'b0000, 4'b0000, 2'd0};
        tbl[4]  = '{4'b1111, 4'b1000, 2'd3};
        tbl[5]  = '{4'b0001, 4'b0001, 2'd0};
        tbl[6]  = '{4'b1010, 4'b0010, 2'd1};
        tbl[7]  = '{4'b1010, 4'b0010, 2'd1};
        tbl[8]  = '{4'b1000, 4'b1000, 2'd3};
        tbl[9]  = '{4'b1000, 4'b1000, 2'd3};
        tbl[10] = '{4'b1000, 4'b1000, 2'd3};
        tbl[11] = '{4'b1000, 4'b1000, 2'd3};
        tbl[12] = '{4'b1000, 4'b1000, 2'd3};
        tbl[13] = '{4'b1001, 4'b1000, 2'd3};
        tbl[14] = '{4'b1001, 4'b1000, 2'd3};
        tbl[15] = '{4'b1001, 4'b1000, 2'd3};
        tbl[16] = '{4'b1001, 4'b0001, 2'd0};
        tbl[17] = '{4'b0110, 4'b0010, 2'd1};
        tbl[18] = '{4'b0100, 4'b0100, 2'd2};
        tbl[19] = '{4'b0000, 4'b0000, 2'd0};
        tbl[20] = '{4'b0011, 4'b0001, 2'd0};
        tbl[21] = '{4'b0000, 4'b0000, 2'd0};

        // Reset asserted with all requests high: outputs stay clear throughout.
        req = 4'b1111;
        #1 rst = 1'b0;
        #1;
        chk_out("rst immediate", 4'b0000, 2'd0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            chk_out($sformatf("rst edge%0d", i), 4'b0000, 2'd0);
            @(negedge clk);
            chk_out($sformatf("rst mid%0d", i), 4'b0000, 2'd0);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_out("first after rst", 4'b0001, 2'd0);

        // Constant full request: each owner holds for exactly MAX_HOLD cycles.
        do_reset();
        for (int e = 1; e <= 20; e++) begin
            int k;
            k = ((e - 1) / 4) % 4;
            step(4'b1111);
            chk_out($sformatf("rotate e%0d", e), one << k, 2'(k));
        end

        do_reset();
        for (int i = 0; i < 22; i++) begin
            step(tbl[i].req);
            chk_out($sformatf("vec%0d", i), tbl[i].g, tbl[i].id);
        end
`ifdef RR_ARB_STATS_EN
        chk("vec grant_count", 32'(grant_count), 32'd10);
        chk("vec preempt_count", 32'(preempt_count), 32'd2);
`endif

        // Reset pulse between edges while requester 2 owns at hold_cnt=3.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(4'b0100);
            chk_out($sformatf("pre-pulse%0d", i), 4'b0100, 2'd2);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_out("pulse immediate", 4'b0000, 2'd0);
        #2;
        rst = 1'b1;
        req = 4'b1111;
        @(posedge clk);
        #1;
        chk_out("after pulse", 4'b0001, 2'd0);

`ifdef RR_ARB_STATS_EN
        // Sole requester re-granted on every hold limit without a gap.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(4'b0001);
            chk_out($sformatf("solo%0d", i), 4'b0001, 2'd0);
        end
        chk("solo grant_count", 32'(grant_count), 32'd3);
        chk("solo preempt_count", 32'(preempt_count), 32'd2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
